// File: rtl/uart_pkg.sv
// uart_pkg
// Shared types and constants for the team UART transmit path.
//   tx_state_t : transmit FSM state encoding (IDLE, START, DATA, STOP)
//   DATA_BITS  : payload bits per frame (8N1 format)
//   START_LVL  : line level during the start bit
//   STOP_LVL   : line level during stop bit(s)
//   IDLE_LVL   : line level while no frame is in flight
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int   DATA_BITS = 8;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/flex_pts_sr.sv
// flex_pts_sr
// Loadable parallel-to-serial shift register.
// Ports:
//   clk          : system clock, rising-edge
//   rst          : synchronous active-high reset, clears the register
//   load_enable  : load parallel_in (has priority over shift_enable)
//   shift_enable : shift one position toward the serial end
//   parallel_in  : NUM_BITS-wide word to load
//   serial_out   : current bit at the serial end (MSB if SHIFT_MSB, else LSB)
module flex_pts_sr #(
  parameter int NUM_BITS  = 8,
  parameter bit SHIFT_MSB = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_enable,
  input  logic                shift_enable,
  input  logic [NUM_BITS-1:0] parallel_in,
  output logic                serial_out
);

  logic [NUM_BITS-1:0] sr;

  // Load wins over shift so a new word is never corrupted by a stale shift.
  // Vacated positions fill with 1 so an over-shifted register reads as idle line.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (load_enable) begin
      sr <= parallel_in;
    end else if (shift_enable) begin
      if (SHIFT_MSB) begin
        sr <= {sr[NUM_BITS-2:0], 1'b1};
      end else begin
        sr <= {1'b1, sr[NUM_BITS-1:1]};
      end
    end
  end

  assign serial_out = SHIFT_MSB ? sr[NUM_BITS-1] : sr[0];

endmodule

// File: rtl/uart_tx.sv
// uart_tx
// Transmit half of the team UART: serialises one byte per handshake as an
// 8N1 frame (start 0, data LSB first, STOP_BITS stop bits at 1).
// Ports:
//   clk        : system clock, all state updates on the rising edge
//   rst        : synchronous active-high reset; aborts any frame in flight
//   tx_data    : byte to send, sampled only on an accepted start
//   tx_start   : send request, accepted only while tx_ready=1
//   tx_ready   : high iff the transmitter is idle
//   tx_done    : one-cycle pulse in the final cycle of the last stop bit
//   serial_out : registered UART line, idles high
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       serial_out
);

  localparam int STOP_CYCLES = STOP_BITS * CLKS_PER_BIT;
  localparam int CNT_W       = (STOP_CYCLES > 1) ? $clog2(STOP_CYCLES) : 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CYCLES - 1);
  localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);

  tx_state_t        state, state_next;
  logic [CNT_W-1:0] cycle_cnt, cycle_cnt_next;
  logic [2:0]       bit_cnt, bit_cnt_next;
  logic             serial_next;
  logic             load_en;
  logic             shift_en;
  logic             sr_bit;

  flex_pts_sr #(
    .NUM_BITS  (DATA_BITS),
    .SHIFT_MSB (1'b0)
  ) u_pts_sr (
    .clk          (clk),
    .rst          (rst),
    .load_enable  (load_en),
    .shift_enable (shift_en),
    .parallel_in  (tx_data),
    .serial_out   (sr_bit)
  );

  // State register: FSM state, timing counters and the registered line.
  // Reset forces the line high so an aborted frame never leaves it low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cycle_cnt  <= '0;
      bit_cnt    <= '0;
      serial_out <= IDLE_LVL;
    end else begin
      state      <= state_next;
      cycle_cnt  <= cycle_cnt_next;
      bit_cnt    <= bit_cnt_next;
      serial_out <= serial_next;
    end
  end

  // Next-state logic. The line value for the next bit is decided at each bit
  // boundary; the shift register is shifted on that same edge, so its serial
  // end always presents the bit that goes out at the following boundary.
  always_comb begin
    state_next     = state;
    cycle_cnt_next = cycle_cnt + CNT_W'(1);
    bit_cnt_next   = bit_cnt;
    serial_next    = serial_out;
    unique case (state)
      IDLE: begin
        cycle_cnt_next = '0;
        serial_next    = IDLE_LVL;
        if (tx_start) begin
          state_next  = START;
          serial_next = START_LVL;
        end
      end
      START: begin
        if (cycle_cnt == BIT_LAST) begin
          state_next     = DATA;
          cycle_cnt_next = '0;
          bit_cnt_next   = '0;
          serial_next    = sr_bit;
        end
      end
      DATA: begin
        if (cycle_cnt == BIT_LAST) begin
          cycle_cnt_next = '0;
          if (bit_cnt == DATA_LAST) begin
            state_next  = STOP;
            serial_next = STOP_LVL;
          end else begin
            bit_cnt_next = bit_cnt + 3'd1;
            serial_next  = sr_bit;
          end
        end
      end
      STOP: begin
        if (cycle_cnt == STOP_LAST) begin
          state_next     = IDLE;
          cycle_cnt_next = '0;
        end
      end
      default: begin
        state_next     = IDLE;
        cycle_cnt_next = '0;
        serial_next    = IDLE_LVL;
      end
    endcase
  end

  // Outputs and datapath controls decoded from the current state.
  // tx_done lives in STOP and tx_ready in IDLE, so they can never overlap.
  always_comb begin
    tx_ready = (state == IDLE);
    tx_done  = (state == STOP) && (cycle_cnt == STOP_LAST);
    load_en  = (state == IDLE) && tx_start;
    shift_en = ((state == START) || (state == DATA)) && (cycle_cnt == BIT_LAST);
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx
// Directed self-checking bench for uart_tx. Instance dut_a uses
// CLKS_PER_BIT=10, STOP_BITS=1; instance dut_b uses CLKS_PER_BIT=4,
// STOP_BITS=2. Outputs are sampled 1 time unit after each rising edge;
// "cycle n" of a frame is the sample taken n edges after the accepting edge.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data_a, tx_data_b;
  logic       tx_start_a, tx_start_b;
  logic       tx_ready_a, tx_ready_b;
  logic       tx_done_a, tx_done_b;
  logic       serial_out_a, serial_out_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(10), .STOP_BITS(1)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data_a),
    .tx_start   (tx_start_a),
    .tx_ready   (tx_ready_a),
    .tx_done    (tx_done_a),
    .serial_out (serial_out_a)
  );

  uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data_b),
    .tx_start   (tx_start_b),
    .tx_ready   (tx_ready_b),
    .tx_done    (tx_done_b),
    .serial_out (serial_out_b)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level at frame cycle n (1-based) for a 1-stop-bit frame of
  // byte d; anything past the data bits is stop/idle high.
  function automatic logic frame_level(input logic [7:0] d, input int n, input int cpb);
    if (n <= cpb) return 1'b0;
    if (n <= 9 * cpb) return d[3'((n - 1) / cpb - 1)];
    return 1'b1;
  endfunction

  // Reset held with tx_start asserted must keep both transmitters idle.
  task automatic test_reset();
    rst        = 1'b1;
    tx_start_a = 1'b1;
    tx_data_a  = 8'hAA;
    tx_start_b = 1'b1;
    tx_data_b  = 8'h55;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c == 2) begin
        rst        = 1'b0;
        tx_start_a = 1'b0;
        tx_start_b = 1'b0;
      end
      checks++;
      if (serial_out_a !== 1'b1) begin
        errors++;
        $display("[TB] FAIL reset_line_a c=%0d: got %b expected 1", c, serial_out_a);
      end
      checks++;
      if (tx_ready_a !== 1'b1) begin
        errors++;
        $display("[TB] FAIL reset_ready_a c=%0d: got %b expected 1", c, tx_ready_a);
      end
      checks++;
      if (tx_done_a !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_done_a c=%0d: got %b expected 0", c, tx_done_a);
      end
      checks++;
      if ({serial_out_b, tx_ready_b, tx_done_b} !== 3'b110) begin
        errors++;
        $display("[TB] FAIL reset_b c=%0d: got line/ready/done %b expected 110",
                 c, {serial_out_b, tx_ready_b, tx_done_b});
      end
    end
  endtask

  // 0xA5 frame against a hand-written per-bit level table.
  task automatic test_frame_a5();
    logic exp_bits [0:9];
    logic exp_line;
    exp_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tx_data_a  = 8'hA5;
    tx_start_a = 1'b1;
    tick();
    tx_start_a = 1'b0;
    for (int n = 1; n <= 101; n++) begin
      if (n > 1) tick();
      exp_line = (n <= 100) ? exp_bits[(n - 1) / 10] : 1'b1;
      checks++;
      if (serial_out_a !== exp_line) begin
        errors++;
        $display("[TB] FAIL a5_line n=%0d: got %b expected %b", n, serial_out_a, exp_line);
      end
      checks++;
      if (tx_done_a !== (n == 100)) begin
        errors++;
        $display("[TB] FAIL a5_done n=%0d: got %b expected %b", n, tx_done_a, (n == 100));
      end
      checks++;
      if (tx_ready_a !== (n == 101)) begin
        errors++;
        $display("[TB] FAIL a5_ready n=%0d: got %b expected %b", n, tx_ready_a, (n == 101));
      end
    end
  endtask

  // 0x00 then 0xFF requested on the first ready cycle: one idle cycle between.
  task automatic test_back_to_back();
    logic [7:0] bytes [0:1];
    logic       exp_line;
    bytes      = '{8'h00, 8'hFF};
    tx_data_a  = bytes[0];
    tx_start_a = 1'b1;
    tick();
    tx_start_a = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int n = 1; n <= 101; n++) begin
        if (n > 1) tick();
        exp_line = frame_level(bytes[f], n, 10);
        checks++;
        if (serial_out_a !== exp_line) begin
          errors++;
          $display("[TB] FAIL b2b_line f=%0d n=%0d: got %b expected %b", f, n, serial_out_a, exp_line);
        end
        checks++;
        if ({tx_done_a, tx_ready_a} !== {(n == 100), (n == 101)}) begin
          errors++;
          $display("[TB] FAIL b2b_hs f=%0d n=%0d: got done/ready %b%b expected %b%b",
                   f, n, tx_done_a, tx_ready_a, (n == 100), (n == 101));
        end
        if (n == 101 && f == 0) begin
          tx_data_a  = bytes[1];
          tx_start_a = 1'b1;
          tick();
          tx_start_a = 1'b0;
          checks++;
          if (serial_out_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_second_start: got %b expected 0", serial_out_a);
          end
          break;
        end
      end
    end
  endtask

  // A request during a 0x81 frame is dropped and never queued.
  task automatic test_busy_reject();
    int   done_count;
    logic exp_line;
    done_count = 0;
    tx_data_a  = 8'h81;
    tx_start_a = 1'b1;
    tick();
    tx_start_a = 1'b0;
    for (int n = 1; n <= 121; n++) begin
      if (n > 1) tick();
      if (tx_done_a === 1'b1) done_count++;
      exp_line = frame_level(8'h81, n, 10);
      checks++;
      if (serial_out_a !== exp_line) begin
        errors++;
        $display("[TB] FAIL busy_line n=%0d: got %b expected %b", n, serial_out_a, exp_line);
      end
      checks++;
      if (tx_ready_a !== (n >= 101)) begin
        errors++;
        $display("[TB] FAIL busy_ready n=%0d: got %b expected %b", n, tx_ready_a, (n >= 101));
      end
      if (n == 40) begin
        tx_data_a  = 8'h3C;
        tx_start_a = 1'b1;
      end
      if (n == 41) tx_start_a = 1'b0;
    end
    checks++;
    if (done_count != 1) begin
      errors++;
      $display("[TB] FAIL busy_done_count: got %0d expected 1", done_count);
    end
  endtask

  // Reset at cycle 55 of a 0x00 frame aborts it; a 0x5A frame then runs clean.
  task automatic test_reset_mid_frame();
    int   done_count;
    logic exp_line;
    done_count = 0;
    tx_data_a  = 8'h00;
    tx_start_a = 1'b1;
    tick();
    tx_start_a = 1'b0;
    for (int n = 1; n <= 55; n++) begin
      if (n > 1) tick();
      if (tx_done_a === 1'b1) done_count++;
      checks++;
      if (serial_out_a !== frame_level(8'h00, n, 10)) begin
        errors++;
        $display("[TB] FAIL abort_line n=%0d: got %b expected %b", n, serial_out_a,
                 frame_level(8'h00, n, 10));
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick();
      if (tx_done_a === 1'b1) done_count++;
      checks++;
      if ({serial_out_a, tx_ready_a} !== 2'b11) begin
        errors++;
        $display("[TB] FAIL abort_idle c=%0d: got line/ready %b%b expected 11",
                 c, serial_out_a, tx_ready_a);
      end
    end
    checks++;
    if (done_count != 0) begin
      errors++;
      $display("[TB] FAIL abort_done_count: got %0d expected 0", done_count);
    end
    tx_data_a  = 8'h5A;
    tx_start_a = 1'b1;
    tick();
    tx_start_a = 1'b0;
    for (int n = 1; n <= 101; n++) begin
      if (n > 1) tick();
      exp_line = frame_level(8'h5A, n, 10);
      checks++;
      if (serial_out_a !== exp_line) begin
        errors++;
        $display("[TB] FAIL after_abort_line n=%0d: got %b expected %b", n, serial_out_a, exp_line);
      end
      checks++;
      if ({tx_done_a, tx_ready_a} !== {(n == 100), (n == 101)}) begin
        errors++;
        $display("[TB] FAIL after_abort_hs n=%0d: got done/ready %b%b expected %b%b",
                 n, tx_done_a, tx_ready_a, (n == 100), (n == 101));
      end
    end
  endtask

  // Two stop bits at 4 clocks per bit: 4 low, 40 high, done at cycle 44.
  task automatic test_stop_bits_two();
    tx_data_b  = 8'hFF;
    tx_start_b = 1'b1;
    tick();
    tx_start_b = 1'b0;
    for (int n = 1; n <= 45; n++) begin
      if (n > 1) tick();
      checks++;
      if (serial_out_b !== (n > 4)) begin
        errors++;
        $display("[TB] FAIL stop2_line n=%0d: got %b expected %b", n, serial_out_b, (n > 4));
      end
      checks++;
      if (tx_done_b !== (n == 44)) begin
        errors++;
        $display("[TB] FAIL stop2_done n=%0d: got %b expected %b", n, tx_done_b, (n == 44));
      end
      checks++;
      if (tx_ready_b !== (n == 45)) begin
        errors++;
        $display("[TB] FAIL stop2_ready n=%0d: got %b expected %b", n, tx_ready_b, (n == 45));
      end
    end
  endtask

  initial begin
    $display("[TB] uart_tx directed tests starting");
    test_reset();
    test_frame_a5();
    test_back_to_back();
    test_busy_reject();
    test_reset_mid_frame();
    test_stop_bits_two();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Transmit half of the team UART. Accepts one 8-bit byte per handshake and serialises it as an 8N1 frame: start bit 0, data LSB first, stop bit(s) 1. Output is a registered line that idles high. Sits opposite the receive path's serial-to-parallel register and uses the same bit period and frame format.

Parameters:
CLKS_PER_BIT, 10, clk cycles per serial bit; legal range >= 2
STOP_BITS, 1, number of stop bits; legal values 1 or 2

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
tx_data  input  8  byte to send; sampled only on an accepted start
tx_start  input  1  request; accepted when tx_ready=1
tx_ready  output  1  high iff state=IDLE
tx_done  output  1  one-cycle pulse in the final cycle of the last stop bit
serial_out  output  1  registered UART line; idle/stop=1, start=0

Behaviour:
- Reset is synchronous and active-high: while rst=1 at a rising clk edge, the block loads state=IDLE, serial_out=1, tx_done=0, bit counter=0, cycle counter=0, shift register=0. rst overrides tx_start in the same edge. Reset mid-frame aborts the frame: the line is high from the next edge and tx_ready=1.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: serial_out=1, tx_ready=1. On an edge with tx_start=1:
  - latch tx_data into the shift register;
  - serial_out<=0;
  - go to START and clear the cycle counter.
- START: hold 0 for CLKS_PER_BIT cycles, then go to DATA. serial_out<=sr[0].
- DATA: each bit is held CLKS_PER_BIT cycles, then the register shifts right. After bit 7, go to STOP with serial_out<=1.
- STOP: hold 1 for STOP_BITS*CLKS_PER_BIT cycles. tx_done=1 during the last cycle of STOP only. Next edge returns to IDLE.
- Timing, with the start accepted at edge k:
  - serial_out=0 during cycles k+1 .. k+CLKS_PER_BIT;
  - data bit i occupies cycles k+1+(i+1)*CLKS_PER_BIT .. k+(i+2)*CLKS_PER_BIT;
  - frame length is (9+STOP_BITS)*CLKS_PER_BIT cycles.
- tx_start while tx_ready=0 is ignored. It is not queued. tx_data changes during a frame have no effect.
- Minimum gap between frames: 1 idle cycle (line high). tx_ready rises in the cycle after tx_done.
- Counter widths:
  - cycle counter: $clog2(STOP_BITS*CLKS_PER_BIT) bits; wraps to 0 at each bit boundary;
  - bit counter: 3 bits, 0..7; no overflow path.
- tx_done and tx_ready are never high in the same cycle.

Decomposition:
- Package uart_pkg:
  - typedef enum tx_state_t {IDLE, START, DATA, STOP};
  - constants DATA_BITS=8, START_LVL=1'b0, STOP_LVL=1'b1, IDLE_LVL=1'b1.
- Sub-module flex_pts_sr (NUM_BITS, SHIFT_MSB) as the parallel-to-serial register: load_enable, shift_enable, parallel_in, serial_out, same clk/rst convention. uart_tx instantiates it with NUM_BITS=8, SHIFT_MSB=0.
- Timing counters and FSM stay in uart_tx.

Test Plan:
- Reset: hold rst=1 for 3 cycles with tx_start=1, then release -> serial_out=1, tx_ready=1, tx_done=0 throughout; no frame starts.
- CLKS_PER_BIT=10, send 0xA5 -> line levels per 10-cycle bit are 0,1,0,1,0,0,1,0,1,1; tx_done pulses exactly at cycle 100 after acceptance; tx_ready=1 at cycle 101.
- Back-to-back: send 0x00, then assert tx_start on the first cycle tx_ready=1 with 0xFF -> frames 0,0×8,1 then 0,1×8,1 separated by exactly one high idle cycle.
- Busy rejection: pulse tx_start with 0x3C at cycle 40 of a 0x81 frame -> 0x81 frame is unchanged; no second frame; tx_done pulses once.
- Reset mid-frame: assert rst at cycle 55 of a 0x00 frame -> serial_out=1 and tx_ready=1 from the next edge; tx_done never pulses; a new tx_start with 0x5A then produces a correct full frame.
- STOP_BITS=2, CLKS_PER_BIT=4, send 0xFF -> start low 4 cycles, line high 40 cycles; tx_done pulses at cycle 44.
